// File: rtl/map_pkg.sv
// Shared map constants: tile ids used by physics and the writer, map geometry,
// and the tile writer FSM state type.
package map_pkg;

    localparam int unsigned TILE_SKY      = 63;
    localparam int unsigned TILE_BRICK    = 1;
    localparam int unsigned TILE_QUESTION = 2;
    localparam int unsigned TILE_USED     = 3;

    localparam int unsigned MAP_COLS = 212;
    localparam int unsigned MAP_ROWS = 19;

    typedef enum logic [2:0] {
        StIdle,
        StRead,
        StDecide,
        StWrite,
        StCooldown
    } writer_state_e;

endpackage

// File: rtl/tile_addr_calc.sv
// Row/column to linear map address, plus a flag saying the tile lies inside the map.
module tile_addr_calc #(
    parameter int unsigned MAP_COLS = map_pkg::MAP_COLS,
    parameter int unsigned MAP_ROWS = map_pkg::MAP_ROWS,
    parameter int unsigned ADDR_W   = 12
) (
    input  logic [4:0]        row,
    input  logic [7:0]        col,
    output logic [ADDR_W-1:0] addr,
    output logic              in_range
);

    // Wide enough for the largest out-of-range product, so nothing wraps before the range test.
    localparam int unsigned ProdW = ADDR_W + 2;

    logic [ProdW-1:0] full;

    assign full     = ProdW'(row) * ProdW'(MAP_COLS) + ProdW'(col);
    assign addr     = full[ADDR_W-1:0];
    assign in_range = (32'(row) < MAP_ROWS) && (32'(col) < MAP_COLS);

endmodule

// File: rtl/map_tile_writer.sv
// Read-modify-write owner of map RAM port B: breaks bricks, spends question blocks,
// then holds off further bumps for a few game ticks while the tile animates.
module map_tile_writer #(
    parameter int unsigned MAP_COLS       = map_pkg::MAP_COLS,
    parameter int unsigned MAP_ROWS       = map_pkg::MAP_ROWS,
    parameter int unsigned ADDR_W         = 12,
    parameter int unsigned ID_W           = 6,
    parameter int unsigned COOLDOWN_TICKS = 3
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              tick_en,
    input  logic              bump_req,
    input  logic [4:0]        bump_row,
    input  logic [7:0]        bump_col,
    output logic              bump_ready,
    output logic [ADDR_W-1:0] rd_addr,
    input  logic [ID_W-1:0]   rd_data,
    output logic              wr_en,
    output logic [ADDR_W-1:0] wr_addr,
    output logic [ID_W-1:0]   wr_data,
    output logic              coin_pulse,
    output logic              break_pulse,
    output logic              bump_active,
    output logic [ADDR_W-1:0] bump_tile
);

    import map_pkg::*;

    localparam int unsigned CntW = $clog2(COOLDOWN_TICKS + 1);

    writer_state_e state_q, state_d;
    logic [ADDR_W-1:0] addr_q, addr_d;
    logic [CntW-1:0]   cnt_q, cnt_d;
    logic [ADDR_W-1:0] rd_addr_q, rd_addr_d;
    logic [ADDR_W-1:0] wr_addr_q, wr_addr_d;
    logic [ID_W-1:0]   wr_data_q, wr_data_d;
    logic              wr_en_q, wr_en_d;
    logic              coin_q, coin_d;
    logic              break_q, break_d;

    logic [ADDR_W-1:0] calc_addr;
    logic              calc_in_range;

    tile_addr_calc #(
        .MAP_COLS(MAP_COLS),
        .MAP_ROWS(MAP_ROWS),
        .ADDR_W  (ADDR_W)
    ) u_addr (
        .row     (bump_row),
        .col     (bump_col),
        .addr    (calc_addr),
        .in_range(calc_in_range)
    );

    always_comb begin
        state_d   = state_q;
        addr_d    = addr_q;
        cnt_d     = cnt_q;
        rd_addr_d = rd_addr_q;
        wr_addr_d = wr_addr_q;
        wr_data_d = wr_data_q;
        wr_en_d   = 1'b0;
        coin_d    = 1'b0;
        break_d   = 1'b0;

        case (state_q)
            StIdle: begin
                // Out-of-range requests are consumed here without leaving idle.
                if (bump_req && calc_in_range) begin
                    addr_d    = calc_addr;
                    rd_addr_d = calc_addr;
                    state_d   = StRead;
                end
            end
            StRead: state_d = StDecide;
            StDecide: begin
                if (rd_data == ID_W'(TILE_BRICK)) begin
                    wr_en_d   = 1'b1;
                    wr_addr_d = addr_q;
                    wr_data_d = ID_W'(TILE_SKY);
                    break_d   = 1'b1;
                    state_d   = StWrite;
                end else if (rd_data == ID_W'(TILE_QUESTION)) begin
                    wr_en_d   = 1'b1;
                    wr_addr_d = addr_q;
                    wr_data_d = ID_W'(TILE_USED);
                    coin_d    = 1'b1;
                    state_d   = StWrite;
                end else begin
                    state_d = StIdle;
                end
            end
            StWrite: begin
                cnt_d   = '0;
                state_d = StCooldown;
            end
            StCooldown: begin
                if (tick_en) begin
                    if (cnt_q == CntW'(COOLDOWN_TICKS - 1)) begin
                        cnt_d   = '0;
                        state_d = StIdle;
                    end else begin
                        cnt_d = cnt_q + 1'b1;
                    end
                end
            end
            default: state_d = StIdle;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q   <= StIdle;
            addr_q    <= '0;
            cnt_q     <= '0;
            rd_addr_q <= '0;
            wr_addr_q <= '0;
            wr_data_q <= '0;
            wr_en_q   <= 1'b0;
            coin_q    <= 1'b0;
            break_q   <= 1'b0;
        end else begin
            state_q   <= state_d;
            addr_q    <= addr_d;
            cnt_q     <= cnt_d;
            rd_addr_q <= rd_addr_d;
            wr_addr_q <= wr_addr_d;
            wr_data_q <= wr_data_d;
            wr_en_q   <= wr_en_d;
            coin_q    <= coin_d;
            break_q   <= break_d;
        end
    end

    assign bump_ready  = (state_q == StIdle);
    assign bump_active = (state_q == StCooldown);
    assign bump_tile   = addr_q;
    assign rd_addr     = rd_addr_q;
    assign wr_en       = wr_en_q;
    assign wr_addr     = wr_addr_q;
    assign wr_data     = wr_data_q;
    assign coin_pulse  = coin_q;
    assign break_pulse = break_q;

endmodule

// File: tb/tb_map_tile_writer.sv
// Bench for map_tile_writer: a behavioural map RAM around the DUT and a tile-map model
// that predicts each bump outcome from the tile rules.
module tb_map_tile_writer;

    localparam int NCOLS = 212;
    localparam int NROWS = 19;
    localparam int NTICK = 3;

    logic        clk = 1'b0;
    logic        rst;
    logic        tick_en;
    logic        bump_req;
    logic [4:0]  bump_row;
    logic [7:0]  bump_col;
    logic        bump_ready;
    logic [11:0] rd_addr;
    logic [5:0]  rd_data;
    logic        wr_en;
    logic [11:0] wr_addr;
    logic [5:0]  wr_data;
    logic        coin_pulse;
    logic        break_pulse;
    logic        bump_active;
    logic [11:0] bump_tile;

    logic        ld_en;
    logic [11:0] ld_addr;
    logic [5:0]  ld_data;

    logic [5:0]  ram   [4096];
    int          model [4096];
    int          wr_count = 0;
    int          checks   = 0;
    int          failures = 0;
    int          exp_rd_addr = 0;

    map_tile_writer dut (
        .clk        (clk),
        .rst        (rst),
        .tick_en    (tick_en),
        .bump_req   (bump_req),
        .bump_row   (bump_row),
        .bump_col   (bump_col),
        .bump_ready (bump_ready),
        .rd_addr    (rd_addr),
        .rd_data    (rd_data),
        .wr_en      (wr_en),
        .wr_addr    (wr_addr),
        .wr_data    (wr_data),
        .coin_pulse (coin_pulse),
        .break_pulse(break_pulse),
        .bump_active(bump_active),
        .bump_tile  (bump_tile)
    );

    always #5 clk = ~clk;

    // Port B of the map RAM: synchronous read, one-cycle latency.
    always @(posedge clk) begin
        if (ld_en) ram[ld_addr] <= ld_data;
        else if (wr_en) ram[wr_addr] <= wr_data;
        rd_data <= ram[rd_addr];
        if (wr_en) wr_count <= wr_count + 1;
    end

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input int obs, input int exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s: observed=%0d expected=%0d", tag, obs, exp);
        end
    endtask

    function automatic int rule_next(input int tile);
        if (tile == 1) return 63;
        if (tile == 2) return 3;
        return tile;
    endfunction

    task automatic do_bump(input int row, input int col, input bit hold);
        int  addr;
        int  tile;
        int  ticks;
        int  guard;
        int  wc0;
        bit  inr;
        inr  = (row < NROWS) && (col < NCOLS);
        addr = row * NCOLS + col;
        chk("pre_ready", bump_ready, 1);
        bump_row = 5'(row);
        bump_col = 8'(col);
        bump_req = 1'b1;
        wc0 = wr_count;
        step();
        if (!hold) bump_req = 1'b0;
        if (!inr) begin
            bump_req = 1'b0;
            repeat (3) begin
                chk("oor_ready", bump_ready, 1);
                chk("oor_rd_addr", rd_addr, exp_rd_addr);
                chk("oor_wr_en", wr_en, 0);
                step();
            end
            return;
        end
        exp_rd_addr = addr;
        tile = model[addr];
        chk("c1_rd_addr", rd_addr, addr);
        chk("c1_ready", bump_ready, 0);
        step();
        chk("c2_wr_en", wr_en, 0);
        step();
        if (rule_next(tile) != tile) begin
            chk("c3_wr_en", wr_en, 1);
            chk("c3_wr_addr", wr_addr, addr);
            chk("c3_wr_data", wr_data, rule_next(tile));
            chk("c3_break", break_pulse, tile == 1 ? 1 : 0);
            chk("c3_coin", coin_pulse, tile == 2 ? 1 : 0);
            chk("c3_ready", bump_ready, 0);
            model[addr] = rule_next(tile);
            // A tick on the cycle cooldown is entered must not count.
            tick_en = 1'($urandom_range(0, 1));
            step();
            tick_en = 1'b0;
            chk("c4_wr_en", wr_en, 0);
            chk("c4_break", break_pulse, 0);
            chk("c4_coin", coin_pulse, 0);
            chk("c4_tile", bump_tile, addr);
            ticks = 0;
            guard = 0;
            while (ticks < NTICK && guard < 200) begin
                chk("cd_active", bump_active, 1);
                chk("cd_ready", bump_ready, 0);
                tick_en = 1'($urandom_range(0, 1));
                step();
                if (tick_en) ticks++;
                tick_en = 1'b0;
                guard++;
            end
            chk("cd_ticks", ticks, NTICK);
            chk("end_active", bump_active, 0);
            chk("end_ready", bump_ready, 1);
            chk("write_count", wr_count - wc0, 1);
        end else begin
            chk("noop_wr_en", wr_en, 0);
            chk("noop_ready", bump_ready, 1);
            chk("noop_pulses", coin_pulse + break_pulse, 0);
            chk("noop_active", bump_active, 0);
            chk("noop_count", wr_count - wc0, 0);
        end
        if (hold) begin
            // Held request is taken on the first idle edge; tile is now inert.
            step();
            bump_req = 1'b0;
            chk("hold_reaccept_ready", bump_ready, 0);
            chk("hold_reaccept_addr", rd_addr, addr);
            step();
            step();
            chk("hold_second_ready", bump_ready, 1);
            chk("hold_total_writes", wr_count - wc0, rule_next(tile) != tile ? 1 : 0);
        end
    endtask

    initial begin
        int mism;
        int r;
        int c;
        rst      = 1'b1;
        tick_en  = 1'b0;
        bump_req = 1'b0;
        bump_row = '0;
        bump_col = '0;
        ld_en    = 1'b0;
        ld_addr  = '0;
        ld_data  = '0;

        for (int i = 0; i < 4096; i++) begin
            case ($urandom_range(0, 5))
                0: model[i] = 0;
                1: model[i] = 1;
                2: model[i] = 2;
                3: model[i] = 3;
                4: model[i] = 63;
                default: model[i] = $urandom_range(4, 62);
            endcase
        end
        model[1928] = 1;
        model[4027] = 2;
        model[1067] = 0;
        model[639]  = 1;
        model[852]  = 2;

        ld_en = 1'b1;
        for (int i = 0; i < 4096; i++) begin
            ld_addr = 12'(i);
            ld_data = 6'(model[i]);
            step();
        end
        ld_en = 1'b0;
        step();

        chk("rst_ready", bump_ready, 1);
        chk("rst_wr_en", wr_en, 0);
        chk("rst_coin", coin_pulse, 0);
        chk("rst_break", break_pulse, 0);
        chk("rst_active", bump_active, 0);
        chk("rst_rd_addr", rd_addr, 0);
        chk("rst_wr_addr", wr_addr, 0);
        chk("rst_wr_data", wr_data, 0);
        chk("rst_bump_tile", bump_tile, 0);
        rst = 1'b0;
        step();

        do_bump(9, 20, 1'b0);
        do_bump(18, 211, 1'b0);
        do_bump(18, 211, 1'b0);
        do_bump(19, 5, 1'b0);
        do_bump(3, 212, 1'b0);
        do_bump(5, 7, 1'b0);
        do_bump(3, 3, 1'b1);

        // Reset while the FSM is deciding: the write must never happen.
        bump_row = 5'd4;
        bump_col = 8'd4;
        bump_req = 1'b1;
        mism = wr_count;
        step();
        bump_req = 1'b0;
        step();
        rst = 1'b1;
        step();
        rst = 1'b0;
        chk("mid_rst_wr_en", wr_en, 0);
        chk("mid_rst_ready", bump_ready, 1);
        chk("mid_rst_rd_addr", rd_addr, 0);
        chk("mid_rst_wr_addr", wr_addr, 0);
        chk("mid_rst_wr_data", wr_data, 0);
        chk("mid_rst_pulses", coin_pulse + break_pulse, 0);
        chk("mid_rst_active", bump_active, 0);
        chk("mid_rst_tile", bump_tile, 0);
        exp_rd_addr = 0;
        step();
        chk("mid_rst_no_write", wr_count - mism, 0);
        do_bump(4, 4, 1'b0);

        for (int n = 0; n < 30; n++) begin
            r = $urandom_range(0, 19);
            c = ($urandom_range(0, 1) == 0) ? $urandom_range(0, 7) : $urandom_range(206, 213);
            do_bump(r, c, 1'($urandom_range(0, 3) == 0));
        end

        step();
        mism = 0;
        for (int i = 0; i < 4096; i++) begin
            if (int'(ram[i]) != model[i]) mism++;
        end
        chk("ram_image", mism, 0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/map_tile_writer.md
# map_tile_writer

Write-side owner of the level tile map: it turns head-hit events from the Mario physics logic into read-modify-write updates of the map RAM. The physics and collision logic only reads tiles. This block breaks bricks into sky, converts question blocks into used blocks, and reports coin and brick events. It sits between the physics logic (request side) and port B of the dual-port map RAM; the renderer and collision readers use the other port.

## Interface
Parameters:
- MAP_COLS, 212, tiles per map row
- MAP_ROWS, 19, rows stored (19*212 = 4028 ≤ 4096)
- ADDR_W, 12, map address width
- ID_W, 6, tile id width
- COOLDOWN_TICKS, 3, tick_en pulses the block stays busy after a write (bump animation)

Ports:
- clk  in  1  system clock; the only clock
- rst  in  1  reset; **synchronous, active-high**
- tick_en  in  1  one-cycle game-tick strobe (0.1 s cadence)
- bump_req  in  1  head-hit request; accepted when bump_req && bump_ready
- bump_row  in  5  tile row of the tile above Mario's head
- bump_col  in  8  absolute tile column of that tile
- bump_ready  out  1  high only in IDLE
- rd_addr  out  ADDR_W  map RAM port-B read address (registered)
- rd_data  in  ID_W  map RAM read data, 1-cycle synchronous latency
- wr_en  out  1  map RAM port-B write strobe
- wr_addr  out  ADDR_W  write address
- wr_data  out  ID_W  write data
- coin_pulse  out  1  one cycle, coincident with the write to a used block
- break_pulse  out  1  one cycle, coincident with the write that breaks a brick
- bump_active  out  1  high during COOLDOWN
- bump_tile  out  ADDR_W  address of the tile being animated; valid while bump_active

## Operation
- Address: addr = bump_row*MAP_COLS + bump_col, computed at acceptance, ADDR_W bits, no truncation (maximum 4027).
- Out-of-range rule: if bump_row ≥ MAP_ROWS or bump_col ≥ MAP_COLS, the request is consumed (ready was high) and dropped. The FSM stays in IDLE and produces no read and no write.
- States:
  - IDLE: on accept, latch addr and go to READ.
  - READ: rd_addr = addr.
  - DECIDE: sample rd_data.
    - TILE_BRICK: write TILE_SKY, raise break_pulse.
    - TILE_QUESTION: write TILE_USED, raise coin_pulse.
    - Any other id: return to IDLE with no write.
  - WRITE: wr_en = 1 for exactly one cycle, then go to COOLDOWN.
  - COOLDOWN: count COOLDOWN_TICKS tick_en pulses, then go to IDLE.
- Requests arriving while busy are ignored and not queued.
- A tick_en in the same cycle the FSM enters COOLDOWN is not counted.

## Timing
- Reset values: bump_ready=1 (IDLE), wr_en=0, coin_pulse=0, break_pulse=0, bump_active=0, rd_addr=0, wr_addr=0, wr_data=0, bump_tile=0, cooldown counter 0.
- Acceptance at edge 0; the following timings are relative to it:
  - rd_addr valid in cycle 1.
  - rd_data sampled at the end of cycle 2.
  - wr_en, wr_addr, wr_data, and the pulse are valid in cycle 3.
  - bump_active rises in cycle 4.
  - bump_ready returns 1 in cycle 3 for no-op tiles.
- Write latency from accept is 3 cycles.
- Reset mid-operation: every state returns to IDLE on the next edge.
  - Reset sampled in DECIDE means no write ever occurs.
  - Reset sampled in WRITE deasserts wr_en on the following edge. The write performed in that cycle stands.
- Write and read on port B never occur in the same cycle.

## Structure
- Shared package map_pkg holds:
  - TILE_SKY=63, TILE_BRICK=1, TILE_QUESTION=2, TILE_USED=3
  - MAP_COLS, MAP_ROWS
  - the state enum
- The physics logic imports the same tile ids.
- One natural sub-module: tile_addr_calc (row/col → address plus in-range flag, purely combinational). The FSM, counter and output registers live in map_tile_writer.

## Test plan
- Brick hit: row 9, col 20 with RAM[1928]=1 → wr_en in cycle 3, wr_addr=1928, wr_data=63, break_pulse=1 for one cycle, bump_active for 3 ticks, then ready.
- Question hit: row 18, col 211 with RAM[4027]=2 → write 3 to 4027, coin_pulse once. A second hit on the same tile then reads 3 and produces no write.
- Out of range: row 19 or col 212 → ready stays 1, no rd_addr change, no wr_en.
- Busy: bump_req held high through the whole operation → exactly one write. The next request is accepted the cycle after COOLDOWN ends.
- Reset mid-operation: rst asserted in DECIDE → no write, all outputs at reset values, ready=1 the next cycle.
- Non-breakable tile: RAM=0 (ground) → no write, ready back in cycle 3, no pulses.
